// File: rtl/risc13_pkg.sv
// Shared encodings for the 13-bit RISC core: opcodes, FSM states,
// instruction field positions and the decoded instruction class.
package risc13_pkg;

    localparam int IW          = 13;
    localparam int TW          = 6;
    localparam int MEM_TIMEOUT = 15;

    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 3;
    localparam int RT_MSB  = 2;
    localparam int RT_LSB  = 0;
    localparam int TGT_MSB = 5;
    localparam int TGT_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic is_alu;
        logic is_imm;
        logic is_ld;
        logic is_st;
        logic is_br;
        logic is_jmp;
        logic is_halt;
        logic is_illegal;
    } instr_class_t;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier used by the multi-cycle controller.
module instr_class_decode
    import risc13_pkg::*;
(
    input  logic [3:0]   i_Opcode,
    output instr_class_t o_Class
);

    always_comb begin
        // NOTE: default every field first so no path through the case infers a latch.
        o_Class = '0;
        case (i_Opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: o_Class.is_alu     = 1'b1;
            OP_ADDI:                               o_Class.is_imm     = 1'b1;
            OP_LD:                                 o_Class.is_ld      = 1'b1;
            OP_ST:                                 o_Class.is_st      = 1'b1;
            OP_BEQ, OP_BNE:                        o_Class.is_br      = 1'b1;
            OP_JMP:                                o_Class.is_jmp     = 1'b1;
            OP_HALT:                               o_Class.is_halt    = 1'b1;
            4'hC, 4'hD, 4'hE:                      o_Class.is_illegal = 1'b1;
            default:                               o_Class            = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: holds the instruction register and sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB, driving PC and datapath controls.
module multicycle_ctrl
    import risc13_pkg::*;
#(
    parameter int P_IW          = IW,
    parameter int P_TW          = TW,
    parameter int P_MEM_TIMEOUT = MEM_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [P_IW-1:0] i_Instr,
    input  logic            i_Zero,
    input  logic            i_MemAck,
    output logic            o_PC,
    output logic            o_PCop,
    output logic [P_TW-1:0] o_Branch,
    output logic [2:0]      o_Rd,
    output logic [2:0]      o_Rs,
    output logic [2:0]      o_Rt,
    output logic [3:0]      o_ALUop,
    output logic            o_ALUsrc,
    output logic            o_RegWrite,
    output logic            o_MemReq,
    output logic            o_MemWrite,
    output logic            o_Halted,
    output logic            o_Illegal,
    output logic            o_Fault
);

    localparam int CW = $clog2(P_MEM_TIMEOUT + 1);

    state_t          r_State;
    logic [P_IW-1:0] r_IR;
    logic [CW-1:0]   r_Wait;
    logic            r_Fault;

    logic [3:0]      w_Op;
    instr_class_t    w_Class;
    logic            w_LastWait;
    logic            w_PC;
    logic            w_PCop;
    logic            w_RegWrite;
    logic            w_MemReq;
    logic            w_Illegal;

    assign w_Op       = r_IR[OP_MSB:OP_LSB];
    assign w_LastWait = (r_Wait == CW'(P_MEM_TIMEOUT - 1));

    instr_class_decode u_decode (
        .i_Opcode (w_Op),
        .o_Class  (w_Class)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_State <= S_FETCH;
            r_IR    <= '0;
            r_Wait  <= '0;
            r_Fault <= 1'b0;
        end else begin
            case (r_State)
                S_FETCH: begin
                    r_IR    <= i_Instr;
                    r_State <= S_DECODE;
                end
                S_DECODE: begin
                    if (w_Class.is_halt)
                        r_State <= S_HALT;
                    else if (w_Op == OP_NOP || w_Class.is_illegal)
                        r_State <= S_FETCH;
                    else
                        r_State <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_Class.is_alu || w_Class.is_imm)
                        r_State <= S_WB;
                    else if (w_Class.is_ld || w_Class.is_st)
                        r_State <= S_MEM;
                    else
                        r_State <= S_FETCH;
                end
                S_MEM: begin
                    if (i_MemAck) begin
                        r_Wait  <= '0;
                        r_State <= w_Class.is_st ? S_FETCH : S_WB;
                    end else if (w_LastWait) begin
                        r_Wait  <= '0;
                        r_Fault <= 1'b1;
                        r_State <= S_HALT;
                    end else begin
                        r_Wait  <= r_Wait + 1'b1;
                    end
                end
                S_WB:    r_State <= S_FETCH;
                S_HALT:  r_State <= S_HALT;
                default: r_State <= S_FETCH;
            endcase
        end
    end

    // Strobes decode from the registered state and IR; branch resolution and
    // the store-ack retire react to i_Zero / i_MemAck within the same cycle.
    always_comb begin
        w_PC       = 1'b0;
        w_PCop     = 1'b0;
        w_RegWrite = 1'b0;
        w_MemReq   = 1'b0;
        w_Illegal  = 1'b0;
        case (r_State)
            S_DECODE: begin
                if (!w_Class.is_halt && (w_Op == OP_NOP || w_Class.is_illegal)) begin
                    w_PC      = 1'b1;
                    w_Illegal = w_Class.is_illegal;
                end
            end
            S_EXEC: begin
                if (w_Op == OP_BEQ) begin
                    w_PC   = 1'b1;
                    w_PCop = i_Zero;
                end else if (w_Op == OP_BNE) begin
                    w_PC   = 1'b1;
                    w_PCop = ~i_Zero;
                end else if (w_Class.is_jmp) begin
                    w_PC   = 1'b1;
                    w_PCop = 1'b1;
                end
            end
            S_MEM: begin
                w_MemReq = 1'b1;
                w_PC     = i_MemAck & w_Class.is_st;
            end
            S_WB: begin
                w_RegWrite = 1'b1;
                w_PC       = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            w_PC       = 1'b0;
            w_PCop     = 1'b0;
            w_RegWrite = 1'b0;
            w_MemReq   = 1'b0;
            w_Illegal  = 1'b0;
        end
    end

    assign o_PC       = w_PC;
    assign o_PCop     = w_PCop;
    assign o_RegWrite = w_RegWrite;
    assign o_MemReq   = w_MemReq;
    assign o_MemWrite = w_MemReq & w_Class.is_st;
    assign o_Illegal  = w_Illegal;
    assign o_Halted   = (r_State == S_HALT);
    assign o_Fault    = r_Fault;
    assign o_Branch   = r_IR[TGT_MSB:TGT_LSB];
    assign o_Rd       = r_IR[RD_MSB:RD_LSB];
    assign o_Rs       = r_IR[RS_MSB:RS_LSB];
    assign o_Rt       = r_IR[RT_MSB:RT_LSB];
    assign o_ALUop    = w_Class.is_br ? OP_SUB : w_Op;
    assign o_ALUsrc   = w_Class.is_imm | w_Class.is_ld | w_Class.is_st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a vector table of whole instructions
// plus hand-written sequences for memory timeout and reset mid-handshake.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [12:0] i_Instr;
    logic        i_Zero;
    logic        i_MemAck;
    logic        o_PC;
    logic        o_PCop;
    logic [5:0]  o_Branch;
    logic [2:0]  o_Rd;
    logic [2:0]  o_Rs;
    logic [2:0]  o_Rt;
    logic [3:0]  o_ALUop;
    logic        o_ALUsrc;
    logic        o_RegWrite;
    logic        o_MemReq;
    logic        o_MemWrite;
    logic        o_Halted;
    logic        o_Illegal;
    logic        o_Fault;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .i_Instr    (i_Instr),
        .i_Zero     (i_Zero),
        .i_MemAck   (i_MemAck),
        .o_PC       (o_PC),
        .o_PCop     (o_PCop),
        .o_Branch   (o_Branch),
        .o_Rd       (o_Rd),
        .o_Rs       (o_Rs),
        .o_Rt       (o_Rt),
        .o_ALUop    (o_ALUop),
        .o_ALUsrc   (o_ALUsrc),
        .o_RegWrite (o_RegWrite),
        .o_MemReq   (o_MemReq),
        .o_MemWrite (o_MemWrite),
        .o_Halted   (o_Halted),
        .o_Illegal  (o_Illegal),
        .o_Fault    (o_Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] instr;
        logic        zero;
        int          ack_delay;   // MEM cycle index (0 = first) on which ack is given
        int          cyc;         // cycles from FETCH through the PC pulse
        logic        pcop;
        int          regw;
        int          mreq;
        int          memw;
        int          ill;
        logic [3:0]  alu;         // expected in cycle 3 (EXEC) when cyc >= 3
        logic        src;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Runs one instruction starting in its FETCH cycle; returns in the PC-pulse cycle.
    task automatic run_vec(input int idx, input vec_t v);
        int         cyc = 0;
        int         mreq_n = 0;
        int         memw_n = 0;
        int         regw_n = 0;
        int         ill_n = 0;
        int         mem_idx = 0;
        logic       done = 1'b0;
        logic       pcop_p = 1'b0;
        logic       regw_p = 1'b0;
        logic       ill_p = 1'b0;
        logic [5:0] br_p = '0;
        logic [2:0] rd_p = '0;
        logic [2:0] rs_p = '0;
        logic [2:0] rt_p = '0;
        logic [3:0] alu3 = '0;
        logic       src3 = 1'b0;
        string      tag;
        tag = $sformatf("v%0d_%04h", idx, v.instr);
        i_Instr = v.instr;
        i_Zero  = v.zero;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            i_MemAck = o_MemReq && (mem_idx == v.ack_delay);
            #1;
            if (o_MemReq) begin
                mreq_n++;
                mem_idx++;
                if (o_MemWrite) memw_n++;
            end
            if (o_RegWrite) regw_n++;
            if (o_Illegal)  ill_n++;
            if (cyc == 3) begin
                alu3 = o_ALUop;
                src3 = o_ALUsrc;
            end
            if (o_PC) begin
                done   = 1'b1;
                pcop_p = o_PCop;
                regw_p = o_RegWrite;
                ill_p  = o_Illegal;
                br_p   = o_Branch;
                rd_p   = o_Rd;
                rs_p   = o_Rs;
                rt_p   = o_Rt;
            end
        end
        check({tag, "_cycles"},  cyc,    v.cyc);
        check({tag, "_pcop"},    pcop_p, v.pcop);
        check({tag, "_branch"},  br_p,   v.instr[5:0]);
        check({tag, "_rd"},      rd_p,   v.instr[8:6]);
        check({tag, "_rs"},      rs_p,   v.instr[5:3]);
        check({tag, "_rt"},      rt_p,   v.instr[2:0]);
        check({tag, "_regw_n"},  regw_n, v.regw);
        check({tag, "_regw_p"},  regw_p, (v.regw != 0));
        check({tag, "_mreq_n"},  mreq_n, v.mreq);
        check({tag, "_memw_n"},  memw_n, v.memw);
        check({tag, "_ill_n"},   ill_n,  v.ill);
        check({tag, "_ill_p"},   ill_p,  (v.ill != 0));
        if (v.cyc >= 3) begin
            check({tag, "_aluop"},  alu3, v.alu);
            check({tag, "_alusrc"}, src3, v.src);
        end
    endtask

    initial begin
        int mreq_n;
        int pc_n;
        int cyc;

        //           instr     z     ack cyc pcop  rw mr mw il alu    src
        vecs[0]  = '{13'h0253, 1'b0, 0,  4,  1'b0, 1, 0, 0, 0, 4'h1, 1'b0}; // ADD r1,r2,r3
        vecs[1]  = '{13'h122A, 1'b1, 0,  3,  1'b1, 0, 0, 0, 0, 4'h2, 1'b0}; // BEQ taken
        vecs[2]  = '{13'h122A, 1'b0, 0,  3,  1'b0, 0, 0, 0, 0, 4'h2, 1'b0}; // BEQ not taken
        vecs[3]  = '{13'h1415, 1'b0, 0,  3,  1'b1, 0, 0, 0, 0, 4'h2, 1'b0}; // BNE taken
        vecs[4]  = '{13'h1415, 1'b1, 0,  3,  1'b0, 0, 0, 0, 0, 4'h2, 1'b0}; // BNE not taken
        vecs[5]  = '{13'h163F, 1'b0, 0,  3,  1'b1, 0, 0, 0, 0, 4'hB, 1'b0}; // JMP
        vecs[6]  = '{13'h0000, 1'b0, 0,  2,  1'b0, 0, 0, 0, 0, 4'h0, 1'b0}; // NOP
        vecs[7]  = '{13'h1805, 1'b0, 0,  2,  1'b0, 0, 0, 0, 1, 4'h0, 1'b0}; // illegal 0xC
        vecs[8]  = '{13'h0253, 1'b0, 0,  4,  1'b0, 1, 0, 0, 0, 4'h1, 1'b0}; // ADD after illegal
        vecs[9]  = '{13'h04D1, 1'b0, 0,  4,  1'b0, 1, 0, 0, 0, 4'h2, 1'b0}; // SUB
        vecs[10] = '{13'h0BFF, 1'b0, 0,  4,  1'b0, 1, 0, 0, 0, 4'h5, 1'b0}; // XOR r7,r7,r7
        vecs[11] = '{13'h0C8D, 1'b0, 0,  4,  1'b0, 1, 0, 0, 0, 4'h6, 1'b1}; // ADDI
        vecs[12] = '{13'h0E51, 1'b0, 0,  5,  1'b0, 1, 1, 0, 0, 4'h7, 1'b1}; // LD, ack with first req
        vecs[13] = '{13'h0E51, 1'b0, 2,  7,  1'b0, 1, 3, 0, 0, 4'h7, 1'b1}; // LD, ack on 3rd req cycle
        vecs[14] = '{13'h100A, 1'b0, 0,  4,  1'b0, 0, 1, 1, 0, 4'h8, 1'b1}; // ST, ack with first req
        vecs[15] = '{13'h100A, 1'b0, 2,  6,  1'b0, 0, 3, 3, 0, 4'h8, 1'b1}; // ST, two waits
        vecs[16] = '{13'h1A00, 1'b0, 0,  2,  1'b0, 0, 0, 0, 1, 4'h0, 1'b0}; // illegal 0xD
        vecs[17] = '{13'h1C3C, 1'b0, 0,  2,  1'b0, 0, 0, 0, 1, 4'h0, 1'b0}; // illegal 0xE

        reset    = 1'b1;
        i_Instr  = 13'h0253;
        i_Zero   = 1'b0;
        i_MemAck = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pc",     o_PC,       1'b0);
        check("rst_regw",   o_RegWrite, 1'b0);
        check("rst_memreq", o_MemReq,   1'b0);
        check("rst_illegal",o_Illegal,  1'b0);
        check("rst_halted", o_Halted,   1'b0);
        check("rst_fault",  o_Fault,    1'b0);
        check("rst_branch", o_Branch,   6'h00);
        check("rst_rd",     o_Rd,       3'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Store that never gets an ack: timeout, fault, park in HALT.
        i_Instr  = 13'h100A;
        mreq_n   = 0;
        pc_n     = 0;
        cyc      = 0;
        while (!o_Halted && cyc < 40) begin
            @(negedge clk);
            i_MemAck = 1'b0;
            #1;
            cyc++;
            if (o_MemReq) mreq_n++;
            if (o_PC)     pc_n++;
        end
        check("to_memreq_cycles", mreq_n,   15);
        check("to_pc_pulses",     pc_n,     0);
        check("to_halted",        o_Halted, 1'b1);
        check("to_fault",         o_Fault,  1'b1);
        check("to_memreq_off",    o_MemReq, 1'b0);
        i_MemAck = 1'b1;
        pc_n = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (o_PC || o_MemReq || o_RegWrite) pc_n++;
        end
        i_MemAck = 1'b0;
        check("halt_strobes", pc_n,     0);
        check("halt_stays",   o_Halted, 1'b1);
        check("halt_fault",   o_Fault,  1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("to_rst_fault",  o_Fault,  1'b0);
        check("to_rst_halted", o_Halted, 1'b0);
        reset = 1'b0;

        // Load waiting on an ack, interrupted by reset, then a HALT.
        i_Instr = 13'h0E51;
        repeat (5) @(negedge clk);
        #1;
        check("mr_memreq_wait", o_MemReq, 1'b1);
        reset = 1'b1;
        #1;
        check("mr_memreq_rst", o_MemReq, 1'b0);
        check("mr_pc_rst",     o_PC,     1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        i_Instr = 13'h1E00;
        pc_n = 0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (o_PC) pc_n++;
        end
        check("mr_not_halted_yet", o_Halted, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            if (o_PC) pc_n++;
        end
        check("mr_halted",  o_Halted, 1'b1);
        check("mr_no_pc",   pc_n,     0);
        check("mr_fault",   o_Fault,  1'b0);
        check("mr_memreq",  o_MemReq, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
